// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arbState_e;

   // Master identifiers; IFU encodes as 0 so cleared registers point at the IFU.
   typedef enum logic {
      MST_IFU = 1'b0,
      MST_LSU = 1'b1
   } mstId_e;

   localparam int unsigned WordW          = 64;
   localparam int unsigned InstW          = 32;
   localparam logic [2:0]  WordOffsetMask = 3'b111;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-requester round-robin grant: on a tie the master that did not win last time wins.
module mem_arb_rr2
   import mem_arb_pkg::*;
(
   input  logic ifuValid,
   input  logic lsuValid,
   input  logic lastGrant,
   input  logic en,
   output logic gntIfu,
   output logic gntLsu
);

   // One-hot grant, forced idle when arbitration is disabled.
   always_comb begin
      gntIfu = 1'b0;
      gntLsu = 1'b0;
      if (en) begin
         if (ifuValid && lsuValid) begin
            if (lastGrant == MST_LSU) begin
               gntIfu = 1'b1;
            end else begin
               gntLsu = 1'b1;
            end
         end else begin
            gntIfu = ifuValid;
            gntLsu = lsuValid;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 64-bit memory between the IFU and the LSU, one transaction at a time.
// Optional macro MEM_ARB_ALIGN_CHECK_EN: IFU requests with addr[1:0] != 0 are answered at once
// with misalign_err instead of touching memory.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [InstW-1:0]  ifu_inst,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wmask,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_en,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              misalign_err
);

   localparam int unsigned     CntW    = $clog2(MEM_LAT + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(MEM_LAT - 1);

   arbState_e         stateQ, stateD;
   logic [CntW-1:0]   cntQ, cntD;
   mstId_e            lastGrantQ, mstQ;
   logic [ADDR_W-1:0] addrQ;
   logic              wenQ;
   logic [DATA_W-1:0] wdataQ;
   logic [7:0]        wmaskQ;
   logic [WordW-1:0]  rdataQ;
   logic              gntIfu, gntLsu, accept, reqMisalign, lastWait, respActive;
   logic              misalignQ;
   logic [InstW-1:0]  instSel;

   // Ready is also held low while reset is asserted.
   mem_arb_rr2 uRr2 (
      .ifuValid  (ifu_req_valid),
      .lsuValid  (lsu_req_valid),
      .lastGrant (lastGrantQ),
      .en        ((stateQ == IDLE) && rst_n),
      .gntIfu    (gntIfu),
      .gntLsu    (gntLsu)
   );

   assign accept   = gntIfu | gntLsu;
   assign lastWait = (stateQ == WAIT) && (cntQ == CntLast);

`ifdef MEM_ARB_ALIGN_CHECK_EN
   assign reqMisalign = gntIfu && (ifu_addr[1:0] != 2'b00);
`else
   assign reqMisalign = 1'b0;
`endif

   // Next-state and latency counter.
   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      unique case (stateQ)
         IDLE: begin
            if (accept) stateD = reqMisalign ? RESP : ISSUE;
         end
         ISSUE: begin
            stateD = WAIT;
            cntD   = '0;
         end
         WAIT: begin
            if (cntQ == CntLast) stateD = RESP;
            else                 cntD   = cntQ + CntW'(1);
         end
         RESP: begin
            stateD = IDLE;
         end
         default: stateD = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= IDLE;
         cntQ   <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
      end
   end

   // Request latch on handshake and read-data capture in the last WAIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastGrantQ <= MST_LSU;
         mstQ       <= MST_IFU;
         addrQ      <= '0;
         wenQ       <= 1'b0;
         wdataQ     <= '0;
         wmaskQ     <= '0;
         misalignQ  <= 1'b0;
         rdataQ     <= '0;
      end else begin
         if (accept) begin
            lastGrantQ <= gntIfu ? MST_IFU : MST_LSU;
            mstQ       <= gntIfu ? MST_IFU : MST_LSU;
            addrQ      <= gntIfu ? ifu_addr : lsu_addr;
            wenQ       <= gntLsu && lsu_wen;
            wdataQ     <= lsu_wdata;
            wmaskQ     <= lsu_wmask;
            misalignQ  <= reqMisalign;
         end
         if (lastWait) rdataQ <= mem_rdata;
      end
   end

   assign ifu_req_ready = gntIfu;
   assign lsu_req_ready = gntLsu;

   assign mem_en    = (stateQ == ISSUE);
   assign mem_wen   = mem_en && wenQ;
   assign mem_addr  = addrQ & ~ADDR_W'(WordOffsetMask);
   assign mem_wdata = wdataQ;
   assign mem_wmask = wmaskQ;

   assign respActive     = (stateQ == RESP);
   assign ifu_resp_valid = respActive && (mstQ == MST_IFU);
   assign lsu_resp_valid = respActive && (mstQ == MST_LSU);

   assign instSel   = addrQ[2] ? rdataQ[WordW-1:InstW] : rdataQ[InstW-1:0];
   assign ifu_inst  = (ifu_resp_valid && !misalignQ) ? instSel : '0;
   assign lsu_rdata = (lsu_resp_valid && !wenQ) ? rdataQ : '0;

`ifdef MEM_ARB_ALIGN_CHECK_EN
   assign misalign_err = ifu_resp_valid && misalignQ;
`else
   assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported 64-bit memory between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time through a valid/ready handshake and sequences it onto the memory port with a fixed latency.
- Returns a single-cycle response to the master that was granted.
- For IFU responses, selects the 32-bit instruction half of the returned 64-bit word using address bit 2.

Parameters:
- ADDR_W, 64, address width of the requests and the memory port.
- DATA_W, 64, memory word width; must be 64.
- MEM_LAT, 1, number of cycles from the memory sampling mem_en to mem_rdata being valid; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address (pc).
- ifu_resp_valid  out  1  one-cycle IFU response pulse.
- ifu_inst  out  32  fetched instruction.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_wdata  in  64  write data.
- lsu_wmask  in  8  byte write mask.
- lsu_resp_valid  out  1  one-cycle LSU response pulse.
- lsu_rdata  out  64  read data; 0 on a write acknowledge.
- mem_en  out  1  memory access strobe.
- mem_wen  out  1  memory write enable.
- mem_addr  out  ADDR_W  8-byte-aligned address (low 3 bits forced to 0).
- mem_wdata  out  64  write data to memory.
- mem_wmask  out  8  byte mask to memory.
- mem_rdata  in  64  memory read data.
- misalign_err  out  1  IFU misalignment error pulse; tied to 0 unless the optional feature is compiled in.

Behaviour:
- FSM states are IDLE, ISSUE, WAIT and RESP. Reset puts the FSM in IDLE and clears every output and register to 0. last_grant resets to LSU, so the IFU wins the first tie.
- IDLE:
  - req_ready is combinational and asserted only for the granted master.
  - If only one master is valid, it is granted.
  - If both are valid, the master other than last_grant is granted (round-robin).
  - ready never asserts outside IDLE.
- Handshake: when valid && ready is high in cycle T, the arbiter latches the address, wen, wdata, wmask and master id, updates last_grant, and enters ISSUE.
- ISSUE (cycle T+1):
  - mem_en=1 for exactly this one cycle.
  - mem_wen is the latched wen.
  - mem_addr is the latched address with bits [2:0]=0; mem_wdata and mem_wmask are driven from the latched values.
  - Next state is WAIT.
- WAIT: a counter runs for MEM_LAT cycles. In the last WAIT cycle (T+1+MEM_LAT), mem_rdata is captured into a register. Next state is RESP.
- RESP (cycle T+2+MEM_LAT): the owning master's resp_valid=1 for one cycle; the next state is IDLE.
  - ifu_inst = latched addr[2] ? rdata[63:32] : rdata[31:0].
  - lsu_rdata = captured rdata for a read, 0 for a write.
  - Responses have no backpressure; the masters must accept them.
- Throughput is one transaction per MEM_LAT+3 cycles.
- A requester may drop valid before it is granted; nothing is latched in that case.
- mem_en, mem_wen and both resp_valid outputs are 0 in every state other than the ones specified above.
- Reset asserted in any state takes effect immediately: the FSM returns to IDLE and all outputs go to 0. An in-flight transaction is discarded and no response is produced after reset is released.
- The counter width is $clog2(MEM_LAT+1). The counter resets to 0 on entry to WAIT.

Optional Feature:
- Macro name: MEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - An accepted IFU request with addr[1:0]≠0 skips ISSUE and WAIT; mem_en is never raised.
  - The next cycle is RESP, with ifu_resp_valid=1, ifu_inst=0 and misalign_err=1 for that cycle.
- Undefined:
  - addr[1:0] is ignored and misalign_err is constant 0.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the master-id enum (MST_IFU/MST_LSU);
  - constants for the 64-bit word, the 32-bit instruction width and the 3-bit word-offset mask.
- Sub-module mem_arb_rr2 holds the two-requester round-robin grant logic: inputs are the two valid signals, last_grant and an enable tied to IDLE; outputs are one-hot grants.

Test Plan (MEM_LAT=1):
- IFU-only read: ifu_addr=0x80000004 accepted at T, memory word 0x00100073_00000413 → mem_en at T+1 with mem_addr=0x80000000; ifu_resp_valid at T+3 with ifu_inst=0x00100073. Repeat with 0x80000000 → ifu_inst=0x00000413.
- Tie after reset: both masters valid at T → IFU granted at T; LSU ready first at T+4; lsu_resp_valid at T+7.
- Both masters held valid for 6 transactions → grants alternate IFU, LSU, IFU, LSU, IFU, LSU; ready asserts every 4 cycles.
- LSU write: addr 0x8000100C, wdata 0xDEADBEEF_CAFEF00D, wmask 0xF0 → at T+1, mem_en=1, mem_wen=1, mem_addr=0x80001008, mem_wmask=0xF0; at T+3, lsu_resp_valid=1 with lsu_rdata=0.
- Reset mid-operation: rst_n driven low during WAIT → mem_en, resp_valid and ready all 0 immediately; after release, no response and the FSM is in IDLE.
- With MEM_ARB_ALIGN_CHECK_EN defined: ifu_addr=0x80000002 → mem_en stays 0; at T+1, ifu_resp_valid=1, misalign_err=1, ifu_inst=0. Without the macro, misalign_err stays 0 and a normal fetch occurs.
